mem_arbiter_fsm: RTL
====================

Name: mem_arbiter_fsm

Overview:
- Arbitrates a single pipelined main-memory port between the I-cache miss path and the D-cache miss and write-through path.
- Drives the pipeline global cache stall, the signal currently tied to 0 in the CPU top-level.
- On a miss it fetches a whole cache line word-by-word and streams fill writes into the requesting cache.
- On a D-cache store it performs a single-word write-through.

Parameters:
- LINE_WORDS, 8: words per cache line. Power of two, 2..16.
- ADDR_W, 16: byte-address width. Words are 16-bit, so word address = byte address with bit 0 = 0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_miss  in  1  I-cache miss, held until i_tag_we is seen.
- i_miss_addr  in  ADDR_W  byte address of the I-miss.
- d_miss  in  1  D-cache load or store miss, held until d_tag_we is seen.
- d_miss_addr  in  ADDR_W  byte address of the D-miss.
- d_wr_req  in  1  write-through store request, held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory access issue, one per cycle.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rvalid  in  1  read data valid; fixed latency, in issue order.
- mem_rdata  in  16  read data.
- fill_data  out  16  line-fill word, equal to mem_rdata.
- fill_word  out  log2(LINE_WORDS)  word index within the line.
- i_fill_we  out  1  I-cache data-array write.
- d_fill_we  out  1  D-cache data-array write.
- i_tag_we  out  1  I-cache tag/valid write; one pulse on the last fill word.
- d_tag_we  out  1  D-cache tag/valid write; one pulse on the last fill word.
- d_wr_ack  out  1  one-cycle pulse when the store is issued.
- stall  out  1  global cache stall to the pipeline.

Behaviour:
- States: IDLE, FILL_ISSUE, FILL_DRAIN, WRITE.
- Reset:
  - State IDLE; counters 0; requester register = none.
  - All outputs 0 except stall, which follows the combinational formula below.
- IDLE decision, one per cycle, in priority order:
  1. d_miss → latch D, base = d_miss_addr with low log2(2*LINE_WORDS) bits cleared; go to FILL_ISSUE.
  2. Else d_wr_req → WRITE.
  3. Else i_miss → latch I, base from i_miss_addr; go to FILL_ISSUE.
  - No memory access is issued in the decision cycle.
- FILL_ISSUE:
  - mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - issue_cnt increments each cycle.
  - After LINE_WORDS issues, go to FILL_DRAIN, or skip straight to IDLE if all returns are already counted.
- Returns, in FILL_ISSUE and FILL_DRAIN:
  - Each mem_rvalid drives fill_data=mem_rdata, fill_word=recv_cnt, and the selected requester's fill_we=1.
  - recv_cnt increments on each mem_rvalid.
  - On the return with recv_cnt = LINE_WORDS-1, the selected tag_we pulses in the same cycle, and the state goes to IDLE next cycle.
- mem_rvalid in IDLE or WRITE is ignored. This covers stale returns after a mid-fill reset.
- WRITE, exactly one cycle:
  - mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1.
  - Next state IDLE.
- stall = i_miss | d_miss | d_wr_req | (state != IDLE). Combinational; no registered delay.
- Starvation: after a D-fill completes, a pending i_miss wins the next IDLE decision only if d_miss is low. D misses are bounded by the pipeline, so no extra fairness logic is used.
- A request that arrives mid-operation is held by the requester and served at the next IDLE decision.
- Requesters must drop miss/wr_req the cycle after tag_we/ack. The arbiter never re-serves in the cycle of tag_we because the state is not IDLE.
- Address arithmetic is modulo 2^ADDR_W. The line base is aligned, so base + offset never crosses the line.
- Fill timing, from the decision cycle T with memory latency L: issues at T+1..T+LINE_WORDS; last return and tag_we at T+LINE_WORDS+L; IDLE at T+LINE_WORDS+L+1.
- Reset asserted in any state aborts the operation at the next edge. No partial tag_we is ever produced.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- When defined:
  - Issue order starts at the missed word: mem_addr = base + 2*((start + issue_cnt) mod LINE_WORDS), with start = word index of the miss address.
  - fill_word = (start + recv_cnt) mod LINE_WORDS.
  - Extra output crit_valid pulses with the first return, so the pipeline can consume the critical word early.
  - stall remains asserted until tag_we.
- When undefined: sequential order from word 0, and crit_valid is absent.

Test Plan:
- I-miss at 0x0046, memory latency 4:
  - mem_addr sequence 0x0040,0x0042,…,0x004E in cycles 1–8 after the decision.
  - i_fill_we with fill_word 0..7 in cycles 5–12; i_tag_we in cycle 12; stall low in cycle 13 after i_miss drops.
- i_miss and d_miss (0x1234) rise in the same cycle:
  - D fill from 0x1230 first, with d_tag_we only.
  - Then I fill; stall stays high throughout.
- d_wr_req addr 0x2002 data 0xBEEF while idle:
  - Decision cycle, then one cycle of mem_en=1, mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF, d_wr_ack=1.
  - Total stall 2 cycles.
- rst pulsed at fill return 3:
  - Next cycle: IDLE, all outputs 0, no tag_we.
  - Stale mem_rvalid pulses afterward cause no fill_we.
- Miss at 0xFFFE: base 0xFFF0, last addr 0xFFFE, no wrap past the line.
- CRITICAL_WORD_FIRST_EN with miss at 0x0046:
  - Addr order 0x0046,0x0048,…,0x004E,0x0040,…,0x0044.
  - fill_word 3,4,…,7,0,1,2; crit_valid on the first return.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, memory and fill bundle for mem_arbiter_fsm.
// crit_valid exists only when CRITICAL_WORD_FIRST_EN is defined.
interface mem_arbiter_if #(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 16
);
   localparam int WW = $clog2(LINE_WORDS);
   logic              i_miss;
   logic [ADDR_W-1:0] i_miss_addr;
   logic              d_miss;
   logic [ADDR_W-1:0] d_miss_addr;
   logic              d_wr_req;
   logic [ADDR_W-1:0] d_wr_addr;
   logic [15:0]       d_wr_data;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_rvalid;
   logic [15:0]       mem_rdata;
   logic [15:0]       fill_data;
   logic [WW-1:0]     fill_word;
   logic              i_fill_we;
   logic              d_fill_we;
   logic              i_tag_we;
   logic              d_tag_we;
   logic              d_wr_ack;
   logic              stall;
`ifdef CRITICAL_WORD_FIRST_EN
   logic              crit_valid;
`endif
   modport master (
      input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
      input  mem_rvalid, mem_rdata,
`ifdef CRITICAL_WORD_FIRST_EN
      output crit_valid,
`endif
      output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
      output i_fill_we, d_fill_we, i_tag_we, d_tag_we, d_wr_ack, stall
   );
   modport slave (
      output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
      output mem_rvalid, mem_rdata,
`ifdef CRITICAL_WORD_FIRST_EN
      input  crit_valid,
`endif
      input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
      input  i_fill_we, d_fill_we, i_tag_we, d_tag_we, d_wr_ack, stall
   );
endinterface

// File: rtl/mem_arbiter_fsm.sv
// mem_arbiter_fsm: shares one pipelined memory port between I/D line fills and D write-through.
// Define CRITICAL_WORD_FIRST_EN to fetch the missed word first and emit crit_valid.
module mem_arbiter_fsm #(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 16
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.master bus_io
);
   localparam int WW    = $clog2(LINE_WORDS);
   localparam int OFF_W = WW + 1;
   typedef enum logic [1:0] {IDLE, FILL_ISSUE, FILL_DRAIN, WRITE} state_e;
   state_e            state_q;
   logic [WW-1:0]     issue_cnt_q, recv_cnt_q;
   logic              sel_i_q, sel_d_q;
   logic [ADDR_W-1:0] base_q, mem_addr_q;
   logic [15:0]       mem_wdata_q;
   logic              mem_en_q, mem_wr_q, d_wr_ack_q;
   logic [ADDR_W-1:0] miss_addr_d, base_d;
   logic [WW-1:0]     first_d, next_d, word_d;
   logic              filling, ret, last, fill_go;
`ifdef CRITICAL_WORD_FIRST_EN
   logic [WW-1:0]     start_q;
`endif
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b, input logic [WW-1:0] w);
      return b + {{(ADDR_W-OFF_W){1'b0}}, w, 1'b0};
   endfunction
   always_comb begin
      miss_addr_d = bus_io.d_miss ? bus_io.d_miss_addr : bus_io.i_miss_addr;
      base_d      = miss_addr_d & ({ADDR_W{1'b1}} << OFF_W);
      fill_go     = bus_io.d_miss | (bus_io.i_miss & ~bus_io.d_wr_req);
      filling     = (state_q == FILL_ISSUE) | (state_q == FILL_DRAIN);
      ret         = filling & bus_io.mem_rvalid;
      last        = ret & (&recv_cnt_q);
`ifdef CRITICAL_WORD_FIRST_EN
      first_d     = miss_addr_d[OFF_W-1:1];
      next_d      = start_q + issue_cnt_q + WW'(1);
      word_d      = start_q + recv_cnt_q;
`else
      first_d     = '0;
      next_d      = issue_cnt_q + WW'(1);
      word_d      = recv_cnt_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         sel_i_q     <= 1'b0;
         sel_d_q     <= 1'b0;
         base_q      <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         d_wr_ack_q  <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
         start_q     <= '0;
`endif
      end else begin
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         d_wr_ack_q  <= 1'b0;
         if (ret) recv_cnt_q <= recv_cnt_q + WW'(1);
         case (state_q)
            IDLE: begin
               issue_cnt_q <= '0;
               recv_cnt_q  <= '0;
               sel_d_q     <= bus_io.d_miss;
               sel_i_q     <= fill_go & ~bus_io.d_miss;
               // memory outputs are registered, so the first access is launched from the decision cycle
               if (fill_go) begin
                  state_q    <= FILL_ISSUE;
                  base_q     <= base_d;
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= word_addr(base_d, first_d);
`ifdef CRITICAL_WORD_FIRST_EN
                  start_q    <= first_d;
`endif
               end else if (bus_io.d_wr_req) begin
                  state_q     <= WRITE;
                  mem_en_q    <= 1'b1;
                  mem_wr_q    <= 1'b1;
                  mem_addr_q  <= bus_io.d_wr_addr;
                  mem_wdata_q <= bus_io.d_wr_data;
                  d_wr_ack_q  <= 1'b1;
               end
            end
            FILL_ISSUE: begin
               if (&issue_cnt_q) begin
                  state_q <= last ? IDLE : FILL_DRAIN;
               end else begin
                  issue_cnt_q <= issue_cnt_q + WW'(1);
                  mem_en_q    <= 1'b1;
                  mem_addr_q  <= word_addr(base_q, next_d);
               end
            end
            FILL_DRAIN: state_q <= last ? IDLE : FILL_DRAIN;
            default:    state_q <= IDLE;
         endcase
      end
   end
   assign bus_io.mem_en    = mem_en_q;
   assign bus_io.mem_wr    = mem_wr_q;
   assign bus_io.mem_addr  = mem_addr_q;
   assign bus_io.mem_wdata = mem_wdata_q;
   assign bus_io.d_wr_ack  = d_wr_ack_q;
   assign bus_io.fill_data = ret ? bus_io.mem_rdata : 16'h0;
   assign bus_io.fill_word = ret ? word_d : '0;
   assign bus_io.i_fill_we = ret & sel_i_q;
   assign bus_io.d_fill_we = ret & sel_d_q;
   assign bus_io.i_tag_we  = last & sel_i_q;
   assign bus_io.d_tag_we  = last & sel_d_q;
   assign bus_io.stall     = bus_io.i_miss | bus_io.d_miss | bus_io.d_wr_req | (state_q != IDLE);
`ifdef CRITICAL_WORD_FIRST_EN
   assign bus_io.crit_valid = ret & (recv_cnt_q == '0);
`endif
endmodule
